// File: rtl/axi4l_sif_win.sv
// AXI4-Lite slave front end that decodes one address window onto the single-beat acc__
// register access protocol. It has independent AW/W capture, DECERR/SLVERR and a backend timeout.
module axi4l_sif_win #(
  parameter int unsigned axi4l__addr_width = 64,
  parameter int unsigned axi4l__data_width = 32,
  parameter logic [axi4l__addr_width-1:0] win_base = '0,
  parameter int unsigned win_span_log2 = 12,
  parameter int unsigned acc_timeout = 256
) (
  input  logic                             sys__clk,
  input  logic                             sys__arst,
  input  logic [axi4l__addr_width-1:0]     axi4l__s_awaddr,
  input  logic [2:0]                       axi4l__s_awprot,
  input  logic                             axi4l__s_awvalid,
  output logic                             axi4l__s_awready,
  input  logic [axi4l__data_width-1:0]     axi4l__s_wdata,
  input  logic [axi4l__data_width/8-1:0]   axi4l__s_wstrb,
  input  logic                             axi4l__s_wvalid,
  output logic                             axi4l__s_wready,
  output logic [1:0]                       axi4l__s_bresp,
  output logic                             axi4l__s_bvalid,
  input  logic                             axi4l__s_bready,
  input  logic [axi4l__addr_width-1:0]     axi4l__s_araddr,
  input  logic [2:0]                       axi4l__s_arprot,
  input  logic                             axi4l__s_arvalid,
  output logic                             axi4l__s_arready,
  output logic [axi4l__data_width-1:0]     axi4l__s_rdata,
  output logic [1:0]                       axi4l__s_rresp,
  output logic                             axi4l__s_rvalid,
  input  logic                             axi4l__s_rready,
  output logic [axi4l__addr_width-1:0]     acc__waddr,
  output logic [axi4l__data_width-1:0]     acc__wdata,
  output logic [axi4l__data_width/8-1:0]   acc__wstrb,
  output logic                             acc__wvalid,
  input  logic                             acc__wready,
  input  logic                             acc__werr,
  output logic [axi4l__addr_width-1:0]     acc__raddr,
  output logic                             acc__rvalid,
  input  logic                             acc__rready,
  input  logic [axi4l__data_width-1:0]     acc__rdata,
  input  logic                             acc__rerr
);

  localparam int unsigned AW = axi4l__addr_width;
  localparam int unsigned DW = axi4l__data_width;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned AddrLsb = $clog2(SW);
  localparam int unsigned CntW = (acc_timeout > 0) ? $clog2(acc_timeout + 1) : 1;
  localparam logic [AW-1:0] SpanMask = (AW'(1) << win_span_log2) - AW'(1);
  localparam logic [AW-1:0] OffMask = SpanMask & ~((AW'(1) << AddrLsb) - AW'(1));
  localparam logic [CntW-1:0] CntLast = CntW'(acc_timeout - 1);
  localparam bit TimeoutEn = (acc_timeout != 0);

  typedef enum logic [1:0] {StWIdle, StWReq, StWResp} w_state_e;
  typedef enum logic [1:0] {StRIdle, StRReq, StRResp} r_state_e;

  function automatic logic win_hit(input logic [AW-1:0] a);
    return (a >> win_span_log2) == (win_base >> win_span_log2);
  endfunction

  function automatic logic [AW-1:0] win_off(input logic [AW-1:0] a);
    return a & OffMask;
  endfunction

  logic unused_prot;
  assign unused_prot = ^{axi4l__s_awprot, axi4l__s_arprot};

  // Write channel
  w_state_e        w_state_q, w_state_d;
  logic            aw_have_q, aw_have_d, w_have_q, w_have_d, aw_hit_q, aw_hit_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic [1:0]      bresp_q, bresp_d;
  logic [CntW-1:0] wcnt_q, wcnt_d;
  logic            aw_hs, w_hs;

  assign axi4l__s_awready = (w_state_q == StWIdle) && !aw_have_q;
  assign axi4l__s_wready  = (w_state_q == StWIdle) && !w_have_q;
  assign axi4l__s_bvalid  = (w_state_q == StWResp);
  assign axi4l__s_bresp   = bresp_q;
  assign acc__wvalid      = (w_state_q == StWReq);
  assign acc__waddr       = waddr_q;
  assign acc__wdata       = wdata_q;
  assign acc__wstrb       = wstrb_q;
  assign aw_hs = axi4l__s_awvalid && axi4l__s_awready;
  assign w_hs  = axi4l__s_wvalid && axi4l__s_wready;

  always_comb begin
    w_state_d = w_state_q;
    aw_have_d = aw_have_q;
    w_have_d  = w_have_q;
    aw_hit_d  = aw_hit_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    wcnt_d    = wcnt_q;
    unique case (w_state_q)
      StWIdle: begin
        if (aw_hs) begin
          waddr_d   = win_off(axi4l__s_awaddr);
          aw_hit_d  = win_hit(axi4l__s_awaddr);
          aw_have_d = 1'b1;
        end
        if (w_hs) begin
          wdata_d  = axi4l__s_wdata;
          wstrb_d  = axi4l__s_wstrb;
          w_have_d = 1'b1;
        end
        if ((aw_have_q || aw_hs) && (w_have_q || w_hs)) begin
          aw_have_d = 1'b0;
          w_have_d  = 1'b0;
          wcnt_d    = '0;
          // aw_hit_d holds either the just-captured or the earlier-captured decode
          if (aw_hit_d) begin
            w_state_d = StWReq;
          end else begin
            w_state_d = StWResp;
            bresp_d   = 2'b11;
          end
        end
      end
      StWReq: begin
        if (acc__wready) begin
          bresp_d   = acc__werr ? 2'b10 : 2'b00;
          w_state_d = StWResp;
        end else if (TimeoutEn && (wcnt_q == CntLast)) begin
          bresp_d   = 2'b10;
          w_state_d = StWResp;
        end else begin
          wcnt_d = wcnt_q + CntW'(1);
        end
      end
      StWResp: begin
        if (axi4l__s_bready) w_state_d = StWIdle;
      end
      default: w_state_d = StWIdle;
    endcase
  end

  always_ff @(posedge sys__clk or posedge sys__arst) begin
    if (sys__arst) begin
      w_state_q <= StWIdle;
      aw_have_q <= 1'b0;
      w_have_q  <= 1'b0;
      aw_hit_q  <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= 2'b00;
      wcnt_q    <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_have_q <= aw_have_d;
      w_have_q  <= w_have_d;
      aw_hit_q  <= aw_hit_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      wcnt_q    <= wcnt_d;
    end
  end

  // Read channel
  r_state_e        r_state_q, r_state_d;
  logic [AW-1:0]   raddr_q, raddr_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;
  logic [CntW-1:0] rcnt_q, rcnt_d;
  logic            ar_hs;

  assign axi4l__s_arready = (r_state_q == StRIdle);
  assign axi4l__s_rvalid  = (r_state_q == StRResp);
  assign axi4l__s_rdata   = rdata_q;
  assign axi4l__s_rresp   = rresp_q;
  assign acc__rvalid      = (r_state_q == StRReq);
  assign acc__raddr       = raddr_q;
  assign ar_hs = axi4l__s_arvalid && axi4l__s_arready;

  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rcnt_d    = rcnt_q;
    unique case (r_state_q)
      StRIdle: begin
        if (ar_hs) begin
          raddr_d = win_off(axi4l__s_araddr);
          rcnt_d  = '0;
          if (win_hit(axi4l__s_araddr)) begin
            r_state_d = StRReq;
          end else begin
            r_state_d = StRResp;
            rdata_d   = '0;
            rresp_d   = 2'b11;
          end
        end
      end
      StRReq: begin
        if (acc__rready) begin
          rdata_d   = acc__rdata;
          rresp_d   = acc__rerr ? 2'b10 : 2'b00;
          r_state_d = StRResp;
        end else if (TimeoutEn && (rcnt_q == CntLast)) begin
          rdata_d   = '0;
          rresp_d   = 2'b10;
          r_state_d = StRResp;
        end else begin
          rcnt_d = rcnt_q + CntW'(1);
        end
      end
      StRResp: begin
        if (axi4l__s_rready) r_state_d = StRIdle;
      end
      default: r_state_d = StRIdle;
    endcase
  end

  always_ff @(posedge sys__clk or posedge sys__arst) begin
    if (sys__arst) begin
      r_state_q <= StRIdle;
      raddr_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      rcnt_q    <= '0;
    end else begin
      r_state_q <= r_state_d;
      raddr_q   <= raddr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rcnt_q    <= rcnt_d;
    end
  end

endmodule
